des_key_sched_iter: RTL and testbench

- Iterative, parametrised DES key-schedule engine that replaces the fixed one/two-position combinational half-key rotators.
- Accepts the post-PC-1 C/D halves once, then emits one rotated CD value per round under valid/ready handshake.
- Supports encrypt order (left rotations) and decrypt order (right rotations, reversed schedule).
- Sits between the PC-1 stage and the PC-2 stage feeding the round pipeline; PC-2 stays outside this block.

---
 rtl/des_key_sched_iter.sv | 129 ++++++++++++
 tb/tb_des_key_sched_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_iter.sv
// Iterative DES key-schedule engine: loads post-PC-1 C/D halves once and emits one
// rotated CD per round (left rotations for encrypt, reversed right rotations for decrypt).
module des_key_sched_iter #(
  parameter int                HALF_W     = 28,
  parameter int                ROUNDS     = 16,
  parameter logic [ROUNDS-1:0] SHIFT_MASK = 16'h7EFC,
  parameter int                RW         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:2*HALF_W-1] in_cd,
  input  logic              in_decrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:2*HALF_W-1] out_cd,
  output logic [RW-1:0]     out_round,
  output logic              out_last
);

  localparam int CW = 2 * HALF_W;
  localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic int shift_of(input int r);
    logic [ROUNDS-1:0] m;
    if (r < 1 || r > ROUNDS) begin
      return 1;
    end else begin
      m = SHIFT_MASK >> (r - 1);
      return m[0] ? 2 : 1;
    end
  endfunction

  function automatic int total_rot();
    int acc;
    acc = 0;
    for (int r = 1; r <= ROUNDS; r++) acc += shift_of(r);
    return acc % HALF_W;
  endfunction

  localparam int T_ROT = total_rot();

  function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] h, input int n);
    logic [2*HALF_W-1:0] dbl;
    dbl = {h, h} << (n % HALF_W);
    return dbl[2*HALF_W-1:HALF_W];
  endfunction

  // A right rotation by n is the left rotation by the complement within the half.
  function automatic logic [CW-1:0] rot_cd(input logic [CW-1:0] cd, input int n, input logic left);
    int amt;
    amt = left ? (n % HALF_W) : ((HALF_W - (n % HALF_W)) % HALF_W);
    return {rotl_half(cd[CW-1:HALF_W], amt), rotl_half(cd[HALF_W-1:0], amt)};
  endfunction

  state_t         r_state, w_state_nxt;
  logic [RW-1:0]  r_cnt, w_cnt_nxt;
  logic [CW-1:0]  r_cd, w_cd_nxt;
  logic           r_dec, w_dec_nxt;
  logic [CW-1:0]  w_in_cd;

  assign w_in_cd = in_cd;

  // State, round counter, working register and latched mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cd    <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cd    <= w_cd_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  // Next-state: load in IDLE, advance one round per accepted output in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cd_nxt    = r_cd;
    w_dec_nxt   = r_dec;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_dec_nxt   = in_decrypt;
          w_cd_nxt    = in_decrypt ? rot_cd(w_in_cd, T_ROT, 1'b1)
                                   : rot_cd(w_in_cd, shift_of(1), 1'b1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (r_cnt == LAST_RND) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + RW'(1);
            w_cd_nxt  = r_dec ? rot_cd(r_cd, shift_of(ROUNDS - int'(r_cnt)), 1'b0)
                              : rot_cd(r_cd, shift_of(int'(r_cnt) + 2), 1'b1);
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_RUN);
  assign out_cd    = r_cd;
  assign out_round = r_cnt;
  assign out_last  = (r_state == S_RUN) && (r_cnt == LAST_RND);

endmodule

// File: tb/tb_des_key_sched_iter.sv
// Scoreboard bench for des_key_sched_iter: default DES build plus a small HALF_W=8/ROUNDS=4 build.
module tb_des_key_sched_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_decrypt;
  logic [0:55] in_cd;
  logic        out_valid, out_ready, out_last;
  logic [0:55] out_cd;
  logic [3:0]  out_round;

  logic        s_in_valid, s_in_ready, s_in_decrypt;
  logic [0:15] s_in_cd;
  logic        s_out_valid, s_out_ready, s_out_last;
  logic [0:15] s_out_cd;
  logic [1:0]  s_out_round;

  des_key_sched_iter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cd(in_cd), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_cd(out_cd),
    .out_round(out_round), .out_last(out_last)
  );

  des_key_sched_iter #(.HALF_W(8), .ROUNDS(4), .SHIFT_MASK(4'b0110), .RW(2)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_cd(s_in_cd), .in_decrypt(s_in_decrypt),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_cd(s_out_cd),
    .out_round(s_out_round), .out_last(s_out_last)
  );

  localparam logic [55:0] KEY = 56'h0000001_8000000;

  // Encrypt schedule for KEY: C = 1 << S(r), D = 1 << ((27 + S(r)) mod 28).
  logic [55:0] enc_tab [16] = '{
    56'h0000002_0000001, 56'h0000004_0000002, 56'h0000010_0000008, 56'h0000040_0000020,
    56'h0000100_0000080, 56'h0000400_0000200, 56'h0001000_0000800, 56'h0004000_0002000,
    56'h0008000_0004000, 56'h0020000_0010000, 56'h0080000_0040000, 56'h0200000_0100000,
    56'h0800000_0400000, 56'h2000000_1000000, 56'h8000000_4000000, 56'h0000001_8000000
  };
  // Small build, C=01 D=80, shifts 1,2,2,1.
  logic [15:0] sm_tab [4] = '{16'h0201, 16'h0804, 16'h2010, 16'h4020};

  int n_tests = 0;
  int n_fail  = 0;
  logic [60:0] exp_q[$];
  logic [18:0] sm_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic dec);
    for (int k = 0; k < 16; k++)
      exp_q.push_back({(dec ? enc_tab[15-k] : enc_tab[k]), 4'(k), (k == 15)});
  endtask

  task automatic load(input logic [55:0] key, input logic dec);
    bit rdy;
    rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        rdy = 1'b1;
        break;
      end
      step();
    end
    chk("load_ready", rdy, 1'b1);
    in_cd = key;
    in_decrypt = dec;
    in_valid = 1'b1;
    push_seq(dec);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_round(input int r, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && (int'(out_round) == r)) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk(name, hit, 1'b1);
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready && (exp_q.size() == 0) && (sm_q.size() == 0)) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk(name, done, 1'b1);
  endtask

  task automatic s_load(input logic dec);
    s_in_cd = 16'h0180;
    s_in_decrypt = dec;
    s_in_valid = 1'b1;
    for (int k = 0; k < 4; k++)
      sm_q.push_back({(dec ? sm_tab[3-k] : sm_tab[k]), 2'(k), (k == 3)});
    step();
    s_in_valid = 1'b0;
  endtask

  // Main-DUT monitor: compare every accepted round against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("enc_unexpected", {out_cd, out_round, out_last}, 64'd0);
      end else begin
        chk($sformatf("round%0d", out_round), {out_cd, out_round, out_last}, exp_q.pop_front());
      end
    end
  end

  // Small-DUT monitor.
  always @(negedge clk) begin
    if (!rst && s_out_valid && s_out_ready) begin
      if (sm_q.size() == 0) begin
        chk("small_unexpected", {s_out_cd, s_out_round, s_out_last}, 64'd0);
      end else begin
        chk($sformatf("small_round%0d", s_out_round), {s_out_cd, s_out_round, s_out_last},
            sm_q.pop_front());
      end
    end
  end

  initial begin
    logic [55:0] held;
    rst = 1'b1; in_valid = 1'b0; in_cd = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_cd = '0; s_in_decrypt = 1'b0; s_out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_cd", out_cd, 56'd0);
    chk("rst_out_round", out_round, 4'd0);
    chk("rst_out_last", out_last, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    step();

    // Encrypt with out_ready high.
    load(KEY, 1'b0);
    chk("enc_lat_valid", out_valid, 1'b1);
    chk("enc_lat_round", out_round, 4'd0);
    wait_round(15, "enc_reach_last");
    step();
    chk("enc_valid_drop", out_valid, 1'b0);
    wait_done("enc_done");

    // Decrypt is the encrypt schedule reversed.
    load(KEY, 1'b1);
    chk("dec_round0_cd", out_cd, 56'h0000001_8000000);
    wait_done("dec_done");

    // Backpressure at round 5.
    load(KEY, 1'b0);
    wait_round(5, "bp_reach5");
    out_ready = 1'b0;
    held = out_cd;
    repeat (3) begin
      step();
      chk("bp_cd_hold", out_cd, held);
      chk("bp_round_hold", out_round, 4'd5);
      chk("bp_last_hold", out_last, 1'b0);
    end
    out_ready = 1'b1;
    wait_done("bp_done");

    // Load while busy is ignored; load presented at out_last is taken next cycle.
    load(KEY, 1'b0);
    wait_round(3, "busy_reach3");
    chk("busy_in_ready", in_ready, 1'b0);
    in_cd = 56'hFFFFFFF_0000000;
    in_decrypt = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_decrypt = 1'b0;
    wait_round(15, "busy_reach_last");
    chk("busy_last_flag", out_last, 1'b1);
    in_cd = KEY;
    in_decrypt = 1'b1;
    in_valid = 1'b1;
    push_seq(1'b1);
    step();
    chk("reload_in_ready", in_ready, 1'b1);
    chk("reload_valid_low", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    chk("reload_valid", out_valid, 1'b1);
    chk("reload_round", out_round, 4'd0);
    wait_done("reload_done");

    // Asynchronous reset mid-cycle at round 7.
    load(KEY, 1'b0);
    wait_round(7, "ar_reach7");
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_out_cd", out_cd, 56'd0);
    chk("ar_out_round", out_round, 4'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    load(KEY, 1'b0);
    chk("ar_restart_round", out_round, 4'd0);
    chk("ar_restart_cd", out_cd, enc_tab[0]);
    wait_done("ar_done");

    // Small parameter build: encrypt then decrypt.
    s_load(1'b0);
    wait_done("small_enc_done");
    step();
    s_load(1'b1);
    chk("small_dec_round0", s_out_cd, 16'h4020);
    wait_done("small_dec_done");

    chk("q_empty", exp_q.size(), 64'd0);
    chk("small_q_empty", sm_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
